// File: rtl/bipolar_pkg.sv
// Shared types and constants for the two's-to-bipolar converter and the bit-plane sequencer.
package bipolar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    localparam int DEF_IN_BITS   = 4;
    localparam int DEF_NUM_LANES = 32;

    // Index width for a plane counter over n planes; never narrower than one bit.
    function automatic int bit_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bipolar_bitplane_sequencer_select.sv
// Combinational bit-plane extraction: picks bit idx of every lane's p/n word and flags an empty plane.
module bitplane_select #(
    parameter int numLanes = 32,
    parameter int outBits  = 3,
    parameter int idxW     = 2
) (
    input  logic [numLanes-1:0][outBits-1:0] vec_p,
    input  logic [numLanes-1:0][outBits-1:0] vec_n,
    input  logic [idxW-1:0]                  idx,
    output logic [numLanes-1:0]              plane_p,
    output logic [numLanes-1:0]              plane_n,
    output logic                             all_zero
);

    always_comb begin
        plane_p = '0;
        plane_n = '0;
        for (int l = 0; l < numLanes; l++) begin
            plane_p[l] = vec_p[l][idx];
            plane_n[l] = vec_n[l][idx];
        end
        all_zero = ~|{plane_p, plane_n};
    end

endmodule

// File: rtl/bipolar_bitplane_sequencer.sv
// Drives bipolar p/n words onto wordline pairs one bit-plane at a time (MSB first) with a one-deep pending slot.
// Optional BIPOLAR_SEQ_ZERO_SKIP_EN: all-zero planes are skipped without a wl_valid strobe or macro wait.
module bipolar_bitplane_sequencer
    import bipolar_pkg::*;
#(
    parameter  int inBits   = DEF_IN_BITS,
    parameter  int numLanes = DEF_NUM_LANES,
    localparam int outBits  = inBits - 1,
    localparam int idxW     = bit_idx_w(outBits)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [numLanes-1:0][outBits-1:0] in_p,
    input  logic [numLanes-1:0][outBits-1:0] in_n,
    output logic [numLanes-1:0]              wl_p,
    output logic [numLanes-1:0]              wl_n,
    output logic                             wl_valid,
    output logic [idxW-1:0]                  bit_idx,
    output logic                             plane_last,
    input  logic                             macro_done,
    output logic                             busy,
    output logic                             vec_done
);

    localparam logic [idxW-1:0] LAST_IDX = idxW'(outBits - 1);

    seq_state_t                      state_q, state_d;
    logic [idxW-1:0]                 bit_q, bit_d;
    logic [numLanes-1:0][outBits-1:0] act_p_q, act_p_d, act_n_q, act_n_d;
    logic [numLanes-1:0][outBits-1:0] pend_p_q, pend_p_d, pend_n_q, pend_n_d;
    logic                            act_v_q, act_v_d, pend_v_q, pend_v_d;
    logic [numLanes-1:0]             wl_p_q, wl_p_d, wl_n_q, wl_n_d;
    logic                            wl_valid_q, wl_valid_d;
    logic                            plane_last_q, plane_last_d;
    logic                            busy_q, busy_d;
    logic                            vec_done_q, vec_done_d;
    logic                            xfer, drain;
    logic [numLanes-1:0]             sel_p, sel_n;
    logic                            sel_zero;

    assign in_ready = ~pend_v_q & ~rst;
    assign xfer     = in_valid & in_ready;

    // Next control and storage state
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        act_p_d    = act_p_q;
        act_n_d    = act_n_q;
        act_v_d    = act_v_q;
        pend_p_d   = pend_p_q;
        pend_n_d   = pend_n_q;
        pend_v_d   = pend_v_q;
        vec_done_d = 1'b0;
        drain      = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    act_p_d = in_p;
                    act_n_d = in_n;
                    act_v_d = 1'b1;
                    bit_d   = LAST_IDX;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = WAIT;
`ifdef BIPOLAR_SEQ_ZERO_SKIP_EN
                if (~|{wl_p_q, wl_n_q}) begin
                    if (bit_q != '0) begin
                        bit_d   = bit_q - 1'b1;
                        state_d = DRIVE;
                    end else begin
                        drain = 1'b1;
                    end
                end
`endif
            end
            WAIT: begin
                if (macro_done) begin
                    if (bit_q != '0) begin
                        bit_d   = bit_q - 1'b1;
                        state_d = DRIVE;
                    end else begin
                        drain = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Finishing the last plane hands over to the pending vector, or to one arriving this cycle.
        if (drain) begin
            vec_done_d = 1'b1;
            if (pend_v_q) begin
                act_p_d  = pend_p_q;
                act_n_d  = pend_n_q;
                pend_v_d = 1'b0;
                bit_d    = LAST_IDX;
                state_d  = DRIVE;
            end else if (xfer) begin
                act_p_d = in_p;
                act_n_d = in_n;
                bit_d   = LAST_IDX;
                state_d = DRIVE;
            end else begin
                act_v_d = 1'b0;
                state_d = IDLE;
            end
        end else if (xfer && state_q != IDLE) begin
            pend_p_d = in_p;
            pend_n_d = in_n;
            pend_v_d = 1'b1;
        end
    end

    bitplane_select #(
        .numLanes (numLanes),
        .outBits  (outBits),
        .idxW     (idxW)
    ) u_select (
        .vec_p    (act_p_d),
        .vec_n    (act_n_d),
        .idx      (bit_d),
        .plane_p  (sel_p),
        .plane_n  (sel_n),
        .all_zero (sel_zero)
    );

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        wl_valid_d = (state_d == DRIVE);
`ifdef BIPOLAR_SEQ_ZERO_SKIP_EN
        if (sel_zero) begin
            wl_valid_d = 1'b0;
        end
`endif
        wl_p_d       = (state_d == IDLE) ? '0 : sel_p;
        wl_n_d       = (state_d == IDLE) ? '0 : sel_n;
        plane_last_d = (state_d != IDLE) && (bit_d == '0);
        busy_d       = act_v_d;
    end

`ifndef BIPOLAR_SEQ_ZERO_SKIP_EN
    logic unused_sel_zero;
    assign unused_sel_zero = sel_zero;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_q        <= '0;
            act_p_q      <= '0;
            act_n_q      <= '0;
            act_v_q      <= 1'b0;
            pend_p_q     <= '0;
            pend_n_q     <= '0;
            pend_v_q     <= 1'b0;
            wl_p_q       <= '0;
            wl_n_q       <= '0;
            wl_valid_q   <= 1'b0;
            plane_last_q <= 1'b0;
            busy_q       <= 1'b0;
            vec_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            act_p_q      <= act_p_d;
            act_n_q      <= act_n_d;
            act_v_q      <= act_v_d;
            pend_p_q     <= pend_p_d;
            pend_n_q     <= pend_n_d;
            pend_v_q     <= pend_v_d;
            wl_p_q       <= wl_p_d;
            wl_n_q       <= wl_n_d;
            wl_valid_q   <= wl_valid_d;
            plane_last_q <= plane_last_d;
            busy_q       <= busy_d;
            vec_done_q   <= vec_done_d;
        end
    end

    assign wl_p       = wl_p_q;
    assign wl_n       = wl_n_q;
    assign wl_valid   = wl_valid_q;
    assign bit_idx    = bit_q;
    assign plane_last = plane_last_q;
    assign busy       = busy_q;
    assign vec_done   = vec_done_q;

endmodule

// File: tb/tb_bipolar_bitplane_sequencer.sv
// Scoreboard bench for bipolar_bitplane_sequencer (inBits=4, numLanes=4) with hand-computed plane tables.
module tb_bipolar_bitplane_sequencer;

    localparam int LANES = 4;
    localparam int OB    = 3;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [LANES-1:0][OB-1:0]   in_p = '0;
    logic [LANES-1:0][OB-1:0]   in_n = '0;
    logic [LANES-1:0]           wl_p, wl_n;
    logic                       wl_valid;
    logic [1:0]                 bit_idx;
    logic                       plane_last;
    logic                       macro_done;
    logic                       busy;
    logic                       vec_done;

    logic md_resp = 1'b0;
    logic md_idle = 1'b0;
    assign macro_done = md_resp | md_idle;

    int   md_delay    = 2;
    logic drive_stray = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   vd_count = 0;
    int   vd_exp   = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    bipolar_bitplane_sequencer #(.inBits(4), .numLanes(LANES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_p(in_p), .in_n(in_n), .wl_p(wl_p), .wl_n(wl_n), .wl_valid(wl_valid),
        .bit_idx(bit_idx), .plane_last(plane_last), .macro_done(macro_done),
        .busy(busy), .vec_done(vec_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Expected planes in presentation order: {bit_idx, wl_p, wl_n, plane_last}.
    task automatic expect_vec(input logic [3:0] p2, n2, p1, n1, p0, n0);
        exp_q.push_back({2'd2, p2, n2, 1'b0});
        exp_q.push_back({2'd1, p1, n1, 1'b0});
        exp_q.push_back({2'd0, p0, n0, 1'b1});
    endtask

    task automatic send(input logic [11:0] p, input logic [11:0] n);
        int w = 0;
        in_p = p; in_n = n; in_valid = 1'b1;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        if (!in_ready) begin
            n_assert++; n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", w);
        end
        @(negedge clk);
        in_valid = 1'b0; in_p = '0; in_n = '0;
        vd_exp++;
    endtask

    task automatic wait_vd(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!vec_done && cyc < 100);
        if (!vec_done) begin
            n_assert++; n_fail++;
            $display("FAIL vec_done_timeout: got no pulse in %0d cycles, required one", cyc);
        end
    endtask

    task automatic wait_plane(input logic [1:0] idx);
        int c = 0;
        do begin @(negedge clk); c++; end while (!(wl_valid && bit_idx == idx) && c < 100);
        if (!(wl_valid && bit_idx == idx)) begin
            n_assert++; n_fail++;
            $display("FAIL plane_timeout: got no plane %0d in %0d cycles, required one", idx, c);
        end
    endtask

    task automatic wait_all();
        int c = 0;
        while (vd_count < vd_exp && c < 300) begin @(negedge clk); c++; end
        chk("vec_done_count", vd_count, vd_exp);
    endtask

    // Macro model: completes each presented plane md_delay cycles after wl_valid.
    initial begin
        forever begin
            @(negedge clk);
            md_resp = 1'b0;
            if (wl_valid && !rst) begin
                md_resp = drive_stray;
                for (int k = 0; k < md_delay; k++) begin
                    @(negedge clk);
                    md_resp = 1'b0;
                end
                md_resp = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every presented plane and counts vec_done pulses.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wl_valid) begin
                    if (exp_q.size() == 0) begin
                        n_assert++; n_fail++;
                        $display("FAIL plane_unexpected: got bit_idx=%0d wl_p=%b wl_n=%b, required no plane",
                                 bit_idx, wl_p, wl_n);
                    end else begin
                        e = exp_q.pop_front();
                        chk("plane", {21'b0, bit_idx, wl_p, wl_n, plane_last}, {21'b0, e});
                    end
                end
                if (vec_done) vd_count++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        int c;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {23'b0, wl_valid, wl_p, wl_n, bit_idx, plane_last, busy, vec_done, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_release", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // Reset in the middle of WAIT at bit_idx=1 aborts the vector without vec_done
        md_delay = 3;
        expect_vec(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        send(12'h003, 12'h004);
        wait_plane(2'd1);
        @(negedge clk);
        chk("pre_reset_wait", {30'b0, busy, wl_valid, bit_idx == 2'd1}, 32'h5);
        #2 rst = 1'b1;
        #1;
        chk("mid_reset_outputs", {23'b0, wl_valid, wl_p, wl_n, bit_idx, plane_last, busy, vec_done, in_ready}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_abort", {31'b0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);
        chk("no_vec_done_after_abort", vd_count, 0);
        chk("idle_after_abort", {31'b0, busy}, 32'd0);
        vd_exp = 0;

        // Single vector, lane0 p=011 n=100, macro_done 2 cycles after each strobe
        md_delay = 2;
        expect_vec(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        send(12'h003, 12'h004);
        chk("first_plane_latency", {28'b0, wl_valid, bit_idx, busy}, {28'b0, 1'b1, 2'd2, 1'b1});
        wait_vd(cyc);
        chk("idle_at_vec_done", {23'b0, busy, wl_valid, wl_p, wl_n}, 32'd0);
        @(negedge clk);
        chk("vec_done_one_cycle", {31'b0, vec_done}, 32'd0);
        wait_all();

        // Immediate completion: 2*outBits cycles from accept to vec_done
        md_delay = 1;
        expect_vec(4'b0100, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 4'b0010);
        send(12'h180, 12'h018);
        wait_vd(cyc);
        chk("fast_vector_cycles", cyc, 6);
        wait_all();

        // Back-to-back: second vector during plane 1 goes to pending, no IDLE between vectors
        md_delay = 2;
        @(negedge clk);
        expect_vec(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        send(12'h003, 12'h004);
        wait_plane(2'd1);
        expect_vec(4'b1000, 4'b0100, 4'b0010, 4'b0100, 4'b1000, 4'b0101);
        send(12'hA10, 12'h1C1);
        chk("pending_full_ready", {30'b0, in_ready, busy}, 32'h1);
        wait_vd(cyc);
        chk("b2b_drive_at_done", {28'b0, wl_valid, bit_idx, in_ready}, {28'b0, 1'b1, 2'd2, 1'b1});
        wait_all();

        // Third vector held while pending is full, accepted once pending moves to active
        @(negedge clk);
        expect_vec(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        send(12'h003, 12'h004);
        expect_vec(4'b1000, 4'b0100, 4'b0010, 4'b0100, 4'b1000, 4'b0101);
        send(12'hA10, 12'h1C1);
        expect_vec(4'b0100, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 4'b0010);
        in_p = 12'h180; in_n = 12'h018; in_valid = 1'b1;
        @(negedge clk);
        chk("third_blocked", {31'b0, in_ready}, 32'd0);
        c = 0;
        while (!in_ready && c < 100) begin @(negedge clk); c++; end
        chk("third_ready_with_handover", {30'b0, in_ready, vec_done}, 32'h3);
        @(negedge clk);
        in_valid = 1'b0; in_p = '0; in_n = '0;
        vd_exp++;
        chk("third_in_pending", {31'b0, in_ready}, 32'd0);
        wait_all();

        // Stray macro_done in IDLE and DRIVE is ignored
        @(negedge clk);
        md_idle = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_stray_ignored", {30'b0, busy, wl_valid}, 32'd0);
        md_idle = 1'b0;
        drive_stray = 1'b1;
        expect_vec(4'b1000, 4'b0100, 4'b0010, 4'b0100, 4'b1000, 4'b0101);
        send(12'hA10, 12'h1C1);
        wait_all();
        drive_stray = 1'b0;

        // All-zero vector
        md_delay = 1;
        @(negedge clk);
`ifdef BIPOLAR_SEQ_ZERO_SKIP_EN
        send(12'h000, 12'h000);
        wait_vd(cyc);
        chk("zero_vector_cycles", cyc, 3);
`else
        expect_vec(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        send(12'h000, 12'h000);
        wait_vd(cyc);
        chk("zero_vector_cycles", cyc, 6);
`endif
        wait_all();

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_vec_done_count", vd_count, vd_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bipolar_bitplane_sequencer.md
Name: bipolar_bitplane_sequencer

Overview:
- Consumes per-lane bipolar p/n magnitude words produced by the two's-to-bipolar converter.
- Drives the analog array's wordline pairs one bit-plane at a time, MSB first.
- Handshakes each plane with the macro's completion strobe.
- Holds one pending vector so the converter can stream back-to-back inputs without bubbles beyond the macro's own latency.

Parameters:
- inBits, 4, two's-complement width at the converter input.
- outBits (localparam), inBits-1, bipolar word width and number of bit-planes.
- numLanes, 32, number of wordline pairs driven in parallel.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream vector valid.
- in_ready  output  1  sequencer can accept a vector.
- in_p  input  [numLanes-1:0][outBits-1:0]  bipolar positive words.
- in_n  input  [numLanes-1:0][outBits-1:0]  bipolar negative words.
- wl_p  output  [numLanes-1:0]  current-plane positive wordline bits.
- wl_n  output  [numLanes-1:0]  current-plane negative wordline bits.
- wl_valid  output  1  one-cycle strobe: a new plane is presented.
- bit_idx  output  $clog2(outBits) (min 1)  index of the presented plane.
- plane_last  output  1  presented plane is plane 0.
- macro_done  input  1  macro finished evaluating the presented plane.
- busy  output  1  a vector is active.
- vec_done  output  1  one-cycle pulse after the last plane's macro_done.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, except in_ready=1 after release. Active and pending registers and their valid flags cleared. State=IDLE, bit_idx=0.
- Storage: active register (p/n words) and pending register, each with a valid flag.
- Accept:
  - in_ready = !pending_valid (registered-flag based; no combinational path from in_valid).
  - A transfer occurs on in_valid && in_ready.
  - In IDLE, the transfer loads the active register directly.
  - Otherwise the transfer loads the pending register.
- FSM states:
  - IDLE: busy=0.
    - On transfer: load active, bit_idx<=outBits-1, go to DRIVE.
  - DRIVE: wl_valid=1 for exactly one cycle.
    - wl_p[l]=active_p[l][bit_idx], wl_n[l]=active_n[l][bit_idx].
    - Go to WAIT.
  - WAIT: wl_valid=0; wl_p, wl_n, bit_idx held stable. On macro_done:
    - If bit_idx!=0: decrement bit_idx, go to DRIVE.
    - Else: vec_done=1 next cycle, and
      - if pending_valid (or a same-cycle transfer is arriving): move that vector to active, clear pending, bit_idx<=outBits-1, go to DRIVE;
      - otherwise go to IDLE.
- Outputs in IDLE: wl_p and wl_n are 0.
- busy: 1 in DRIVE and WAIT.
- Latency: first wl_valid occurs 1 cycle after the accepting edge. Each plane costs 1 cycle plus the macro wait. A vector with immediate macro_done completes in 2*outBits cycles.
- Ignored inputs: macro_done in IDLE or DRIVE is ignored. No error flag is raised.
- Simultaneous events: a pending-load and an active-drain in the same cycle are both honoured. The pending slot frees and in_ready rises the following cycle.
- Full condition: in_valid held while pending_valid=1 leaves in_ready=0. The data must be held upstream (valid/ready rule: valid and data stable until accepted).
- Reset mid-operation aborts all planes. No vec_done is issued.

Optional Feature:
- Macro: BIPOLAR_SEQ_ZERO_SKIP_EN.
- Enabled:
  - On entering DRIVE, a plane whose wl_p and wl_n are all-zero across every lane is skipped.
  - No wl_valid is issued and no macro_done is awaited.
  - bit_idx advances one plane per cycle.
  - An all-zero vector produces vec_done 1 cycle after entering DRIVE at the last plane, with no wl_valid.
- Disabled: every plane is always driven and awaited.

Decomposition:
- Shared package bipolar_pkg:
  - seq_state_t enum (IDLE, DRIVE, WAIT).
  - Default lane and bit constants used by the converter and the sequencer.
  - A bit-index width function.
- One natural sub-module, bitplane_select: combinational plane extraction (lanes × outBits → lanes for a given index) plus the all-zero detect.

Test Plan:
- Reset mid-WAIT (bit_idx=1) → all outputs 0 immediately, in_ready=1 after release, no vec_done.
- Single vector, inBits=4, numLanes=4, lane0 p=3'b011 n=3'b100, macro_done 2 cycles after each wl_valid → planes at bit_idx 2,1,0 with wl_p[0]=0,1,1 and wl_n[0]=1,0,0; plane_last only on bit_idx 0; vec_done once.
- Back-to-back: second vector offered during the first vector's plane 1 → accepted into pending, in_ready=0 until drain. DRIVE of vector 2 occurs the cycle after the final WAIT, with no IDLE.
- Third vector while pending is full → in_ready=0; data is not corrupted; it is accepted the cycle after pending moves to active.
- macro_done pulsed during IDLE and DRIVE → ignored; plane sequence and counts unchanged.
- With BIPOLAR_SEQ_ZERO_SKIP_EN, all-zero vector → zero wl_valid and vec_done within outBits+1 cycles. Without the macro → 3 wl_valid strobes.
